// File: rtl/double_data_buf.sv
// Ping-pong data store: one write port fills one bank while PORT_NUM read
// ports read the other; the banks swap when a write burst ends.
module double_data_buf #(
  parameter int DEPTH      = 32,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int PORT_NUM   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          wr_addr_1P,
  input  logic [WIDTH-1:0]               wr_data_1P,
  input  logic                           wr_en,
  input  logic                           rd_en,
  input  logic [PORT_NUM*ADDR_WIDTH-1:0] rd_addr_NP,
  output logic [PORT_NUM*WIDTH-1:0]      rd_data_NP,
  output logic                           rd_bank
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]          bank_mem [2][DEPTH];
  logic                      rd_bank_q,   rd_bank_d;
  logic                      wr_en_dly_q, wr_en_dly_d;
  logic [PORT_NUM*WIDTH-1:0] rd_data_q,   rd_data_d;
  logic                      wr_hit;
  logic [IDX_W-1:0]          wr_idx;

  assign wr_hit = wr_en && (wr_addr_1P < ADDR_WIDTH'(DEPTH));
  assign wr_idx = wr_addr_1P[IDX_W-1:0];

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_data_d   = rd_data_q;
    wr_en_dly_d = wr_en;
    // The read issued on the swap edge still sees the old bank.
    rd_bank_d   = rd_bank_q ^ (wr_en_dly_q & ~wr_en);
    if (rd_en) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        if (rd_addr_NP[k*ADDR_WIDTH +: ADDR_WIDTH] < ADDR_WIDTH'(DEPTH))
          rd_data_d[k*WIDTH +: WIDTH] = bank_mem[rd_bank_q][rd_addr_NP[k*ADDR_WIDTH +: IDX_W]];
        else
          rd_data_d[k*WIDTH +: WIDTH] = '0;
      end
    end
  end

  // NOTE: storage arrays carry no reset; contents survive rst and a reset
  // branch here would prevent mapping onto RAM.
  always_ff @(posedge clk) begin
    if (wr_hit)
      bank_mem[~rd_bank_q][wr_idx] <= wr_data_1P;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together on the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q   <= '0;
      rd_bank_q   <= 1'b1;
      wr_en_dly_q <= 1'b0;
    end else begin
      rd_data_q   <= rd_data_d;
      rd_bank_q   <= rd_bank_d;
      wr_en_dly_q <= wr_en_dly_d;
    end
  end

  assign rd_data_NP = rd_data_q;
  assign rd_bank    = rd_bank_q;

endmodule

// File: tb/tb_double_data_buf.sv
// Bench for double_data_buf: directed burst/boundary/swap/reset scenarios,
// then randomized traffic against a bank-level behavioural model.
module tb_double_data_buf;
  localparam int DEPTH = 32;
  localparam int WIDTH = 8;
  localparam int AW    = 16;
  localparam int NP    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     wr_addr_1P;
  logic [WIDTH-1:0]  wr_data_1P;
  logic              wr_en;
  logic              rd_en;
  logic [NP*AW-1:0]  rd_addr_NP;
  logic [NP*WIDTH-1:0] rd_data_NP;
  logic              rd_bank;

  int n_cmp = 0;
  int n_err = 0;

  // Model: two arrays, the bank being read, whether a burst is in progress,
  // and the value each read port should present.
  logic [WIDTH-1:0] m_mem [2][DEPTH];
  bit               m_rd_bank;
  bit               m_in_burst;
  logic [WIDTH-1:0] m_exp [NP];

  double_data_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW), .PORT_NUM(NP)) dut (
    .clk(clk), .rst(rst), .wr_addr_1P(wr_addr_1P), .wr_data_1P(wr_data_1P),
    .wr_en(wr_en), .rd_en(rd_en), .rd_addr_NP(rd_addr_NP),
    .rd_data_NP(rd_data_NP), .rd_bank(rd_bank)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] port_data(input int k);
    return rd_data_NP[k*WIDTH +: WIDTH];
  endfunction

  task automatic model_reset();
    m_rd_bank  = 1'b1;
    m_in_burst = 1'b0;
    for (int k = 0; k < NP; k++) m_exp[k] = '0;
  endtask

  // Drives one cycle from a falling edge, lets the rising edge happen,
  // advances the model, and returns at the next falling edge.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                      input logic re, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    logic [AW-1:0] ra [NP];
    ra = '{a0, a1, a2, a3};
    wr_en = we; wr_addr_1P = wa; wr_data_1P = wd; rd_en = re;
    for (int k = 0; k < NP; k++) rd_addr_NP[k*AW +: AW] = ra[k];
    @(posedge clk);
    if (re)
      for (int k = 0; k < NP; k++)
        m_exp[k] = (ra[k] < DEPTH) ? m_mem[m_rd_bank][ra[k][4:0]] : '0;
    if (we && wa < DEPTH) m_mem[!m_rd_bank][wa[4:0]] = wd;
    if (m_in_burst && !we) m_rd_bank = !m_rd_bank;
    m_in_burst = we;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (rd_data_NP !== '0) begin
      n_err++; $display("FAIL reset_data: got %h expected 0", rd_data_NP);
    end
    n_cmp++;
    if (rd_bank !== 1'b1) begin
      n_err++; $display("FAIL reset_bank: got %b expected 1", rd_bank);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_burst_a();
    logic [WIDTH-1:0] want [NP];
    for (int i = 0; i < 6; i++) step(1'b1, AW'(i), WIDTH'(2*i+1), 1'b0, 0, 0, 0, 0);
    n_cmp++;
    if (rd_bank !== 1'b1) begin
      n_err++; $display("FAIL burst_a_no_early_swap: got %b expected 1", rd_bank);
    end
    step(1'b0, 0, 0, 1'b0, 0, 0, 0, 0);
    n_cmp++;
    if (rd_bank !== 1'b0) begin
      n_err++; $display("FAIL burst_a_swap: got %b expected 0", rd_bank);
    end
    want = '{8'd3, 8'd5, 8'd7, 8'd9};
    step(1'b0, 0, 0, 1'b1, 1, 2, 3, 4);
    for (int k = 0; k < NP; k++) begin
      n_cmp++;
      if (port_data(k) !== want[k]) begin
        n_err++; $display("FAIL burst_a_read port%0d: got %0d expected %0d", k, port_data(k), want[k]);
      end
    end
    step(1'b0, 0, 0, 1'b0, 20, 21, 22, 23);
    for (int k = 0; k < NP; k++) begin
      n_cmp++;
      if (port_data(k) !== want[k]) begin
        n_err++; $display("FAIL burst_a_hold port%0d: got %0d expected %0d", k, port_data(k), want[k]);
      end
    end
  endtask

  task automatic test_burst_b();
    logic [WIDTH-1:0] want [NP];
    want = '{8'd3, 8'd5, 8'd7, 8'd9};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, AW'(6+i), WIDTH'(13+2*i), 1'b1, 1, 2, 3, 4);
      for (int k = 0; k < NP; k++) begin
        n_cmp++;
        if (port_data(k) !== want[k]) begin
          n_err++; $display("FAIL burst_b_bank0_read port%0d: got %0d expected %0d", k, port_data(k), want[k]);
        end
      end
    end
    step(1'b0, 0, 0, 1'b0, 0, 0, 0, 0);
    n_cmp++;
    if (rd_bank !== 1'b1) begin
      n_err++; $display("FAIL burst_b_swap: got %b expected 1", rd_bank);
    end
    want = '{8'd15, 8'd17, 8'd19, 8'd21};
    step(1'b0, 0, 0, 1'b1, 7, 8, 9, 10);
    for (int k = 0; k < NP; k++) begin
      n_cmp++;
      if (port_data(k) !== want[k]) begin
        n_err++; $display("FAIL burst_b_read port%0d: got %0d expected %0d", k, port_data(k), want[k]);
      end
    end
  endtask

  task automatic test_burst_c();
    logic [WIDTH-1:0] want [NP];
    for (int i = 0; i < 6; i++) step(1'b1, AW'(11+i), WIDTH'(25+2*i), 1'b0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 1'b0, 0, 0, 0, 0);
    n_cmp++;
    if (rd_bank !== 1'b0) begin
      n_err++; $display("FAIL burst_c_swap: got %b expected 0", rd_bank);
    end
    want = '{8'd27, 8'd29, 8'd31, 8'd33};
    step(1'b0, 0, 0, 1'b1, 12, 13, 14, 15);
    for (int k = 0; k < NP; k++) begin
      n_cmp++;
      if (port_data(k) !== want[k]) begin
        n_err++; $display("FAIL burst_c_read port%0d: got %0d expected %0d", k, port_data(k), want[k]);
      end
    end
    // Same address on every port; also shows bank0 kept burst A data.
    step(1'b0, 0, 0, 1'b1, 1, 1, 1, 1);
    for (int k = 0; k < NP; k++) begin
      n_cmp++;
      if (port_data(k) !== 8'd3) begin
        n_err++; $display("FAIL same_addr_read port%0d: got %0d expected 3", k, port_data(k));
      end
    end
  endtask

  task automatic test_boundary();
    logic [WIDTH-1:0] want [NP];
    // Address 40 aliases to 8 if truncated, so port 1 reads word 8.
    step(1'b1, 40, 8'hAA, 1'b0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 1'b0, 0, 0, 0, 0);
    n_cmp++;
    if (rd_bank !== 1'b1) begin
      n_err++; $display("FAIL boundary_swap: got %b expected 1", rd_bank);
    end
    want = '{8'd15, 8'd17, 8'd0, 8'd21};
    step(1'b0, 0, 0, 1'b1, 7, 8, 40, 10);
    for (int k = 0; k < NP; k++) begin
      n_cmp++;
      if (port_data(k) !== want[k]) begin
        n_err++; $display("FAIL boundary_read port%0d: got %0d expected %0d", k, port_data(k), want[k]);
      end
    end
  endtask

  task automatic test_swap_during_read();
    logic [WIDTH-1:0] want [NP];
    // Word 11 is 23 in bank1 (burst B) and 25 in bank0 (burst C).
    step(1'b1, 20, 8'h44, 1'b1, 11, 11, 11, 11);
    step(1'b1, 21, 8'h45, 1'b1, 11, 11, 11, 11);
    step(1'b0, 0, 0, 1'b1, 11, 11, 11, 11);
    for (int k = 0; k < NP; k++) begin
      n_cmp++;
      if (port_data(k) !== 8'd23) begin
        n_err++; $display("FAIL swap_edge_read port%0d: got %0d expected 23", k, port_data(k));
      end
    end
    n_cmp++;
    if (rd_bank !== 1'b0) begin
      n_err++; $display("FAIL swap_edge_bank: got %b expected 0", rd_bank);
    end
    want = '{8'd25, 8'h44, 8'h45, 8'd3};
    step(1'b0, 0, 0, 1'b1, 11, 20, 21, 1);
    for (int k = 0; k < NP; k++) begin
      n_cmp++;
      if (port_data(k) !== want[k]) begin
        n_err++; $display("FAIL swap_next_read port%0d: got %0d expected %0d", k, port_data(k), want[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [WIDTH-1:0] want [NP];
    // Burst in progress into bank1 when reset hits between clock edges.
    step(1'b1, 5, 8'h77, 1'b0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (rd_data_NP !== '0) begin
      n_err++; $display("FAIL async_reset_data: got %h expected 0", rd_data_NP);
    end
    n_cmp++;
    if (rd_bank !== 1'b1) begin
      n_err++; $display("FAIL async_reset_bank: got %b expected 1", rd_bank);
    end
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    want = '{8'h77, 8'd13, 8'd23, 8'd0};
    step(1'b0, 0, 0, 1'b1, 5, 6, 11, 40);
    for (int k = 0; k < NP; k++) begin
      n_cmp++;
      if (port_data(k) !== want[k]) begin
        n_err++; $display("FAIL post_reset_read port%0d: got %0d expected %0d", k, port_data(k), want[k]);
      end
    end
    n_cmp++;
    if (rd_bank !== 1'b1) begin
      n_err++; $display("FAIL post_reset_bank: got %b expected 1", rd_bank);
    end
  endtask

  task automatic test_random();
    logic we;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < DEPTH; a++) step(1'b1, AW'(a), WIDTH'($urandom), 1'b0, 0, 0, 0, 0);
      step(1'b0, 0, 0, 1'b0, 0, 0, 0, 0);
    end
    we = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) we = ~we;
      step(we, AW'($urandom_range(0, 39)), WIDTH'($urandom), 1'($urandom),
           AW'($urandom_range(0, 39)), AW'($urandom_range(0, 39)),
           AW'($urandom_range(0, 39)), AW'($urandom_range(0, 39)));
      for (int k = 0; k < NP; k++) begin
        n_cmp++;
        if (port_data(k) !== m_exp[k]) begin
          n_err++; $display("FAIL random_read cyc%0d port%0d: got %0d expected %0d", i, k, port_data(k), m_exp[k]);
        end
      end
      n_cmp++;
      if (rd_bank !== m_rd_bank) begin
        n_err++; $display("FAIL random_bank cyc%0d: got %b expected %b", i, rd_bank, m_rd_bank);
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr_1P = '0; wr_data_1P = '0; rd_addr_NP = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_burst_a();
    test_burst_b();
    test_burst_c();
    test_boundary();
    test_swap_during_read();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
